rca_mul_seq: RTL and testbench

//  Multi-cycle unsigned shift-add multiplier controller built around one rca adder instance.

---
 rtl/rca_mul_seq.sv | 155 +++++++++++++++
 tb/tb_rca_mul_seq.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rca_mul_seq.sv
// rca_mul_seq: multi-cycle unsigned shift-add multiplier built around a single
// ripple-carry adder (rca). Each RUN cycle performs one adder pass: it adds the
// multiplicand to the upper half of the partial product and then shifts the
// partial product right by one. A start/busy/done handshake delivers a 2N-bit
// product.
// Optional build macro: RCA_MUL_EARLY_TERM_EN. When this macro is defined, the
// sequence finishes early as soon as all remaining multiplier bits are zero.

// N-bit ripple-carry adder with no carry-in. The carry-out appears in s[N].
module rca #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N:0]   s
);

  logic [N:0] c;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign s[N] = c[N];

endmodule

module rca_mul_seq #(
  parameter int N     = 32,
  parameter int CNT_W = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  state_t           state;
  logic [N-1:0]     mcand;
  logic [2*N-1:0]   p;
  logic [CNT_W-1:0] cnt;

  logic [N-1:0]     add_b;
  logic [N:0]       s;
  logic [2*N-1:0]   p_next;

  // Increment the iteration counter with plain gate logic. This keeps every
  // addition in this module off the '+' operator.
  function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
    logic carry;
    carry = 1'b1;
    for (int i = 0; i < CNT_W; i++) begin
      inc[i] = v[i] ^ carry;
      carry  = v[i] & carry;
    end
  endfunction

  // The multiplier LSB gates the multiplicand into the adder.
  assign add_b = p[0] ? mcand : '0;

  rca #(.N(N)) u_rca (
    .a (p[2*N-1:N]),
    .b (add_b),
    .s (s)
  );

  // The carry-out s[N] becomes the new MSB, so it is not lost when operands are near 2**N-1.
  assign p_next = {s, p[N-1:1]};

`ifdef RCA_MUL_EARLY_TERM_EN
  logic [N-1:0]   live_mask;
  logic           rest_zero;
  logic [3*N-1:0] et_wide;
  logic [2*N-1:0] et_product;

  // The low N-cnt bits of p are the multiplier bits that have not been processed yet.
  // Once they are all zero, shifting p right by N-cnt gives the final product.
  // That shift is computed as (p << cnt) >> N in a 3N-bit field.
  assign live_mask  = {N{1'b1}} >> cnt;
  assign rest_zero  = (p[N-1:0] & live_mask) == '0;
  assign et_wide    = {{N{1'b0}}, p} << cnt;
  assign et_product = et_wide[3*N-1:N];
`endif

  // Controller FSM: the datapath registers and the outputs are updated together.
  // NOTE: every register here uses <= so that all of them sample pre-edge values, as flops do.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      cnt     <= '0;
      mcand   <= '0;
      p       <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand <= a;
            p     <= {{N{1'b0}}, b};
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
`ifdef RCA_MUL_EARLY_TERM_EN
          if (rest_zero) begin
            product <= et_product;
            done    <= 1'b1;
            state   <= DONE;
          end else
`endif
          begin
            p   <= p_next;
            cnt <= inc(cnt);
            if (cnt == LAST) begin
              product <= p_next;
              done    <= 1'b1;
              state   <= DONE;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rca_mul_seq.sv
// tb_rca_mul_seq: self-checking bench for rca_mul_seq. It covers directed
// corner cases and randomized operands. Each result is checked against a
// reference model that uses plain arithmetic. The model also predicts latency
// for both builds, with and without RCA_MUL_EARLY_TERM_EN.
`timescale 1ns/1ps

module tb_rca_mul_seq;

  localparam int N     = 32;
  localparam int CNT_W = 6;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;

  int tests = 0;
  int fails = 0;

  rca_mul_seq #(.N(N), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  // Reference model: the product is computed with ordinary multiplication.
  function automatic logic [2*N-1:0] ref_product(input logic [N-1:0] x, input logic [N-1:0] y);
    logic [2*N-1:0] xx;
    logic [2*N-1:0] yy;
    xx = {{N{1'b0}}, x};
    yy = {{N{1'b0}}, y};
    return xx * yy;
  endfunction

  // Reference model: the number of edges from the accepting edge until done is visible.
  function automatic int ref_latency(input logic [N-1:0] y);
`ifdef RCA_MUL_EARLY_TERM_EN
    int msb;
    if (y == '0) return 1;
    msb = 0;
    for (int i = 0; i < N; i++) if (y[i]) msb = i;
    return (msb + 2 < N) ? msb + 2 : N;
`else
    return N;
`endif
  endfunction

  // Runs one operation. It can optionally inject a start pulse (inj_rst=0) or a
  // reset (inj_rst=1) after inj_at post-accept edges. It returns the observed
  // latency (-1 when the operation was abandoned), the product at done, the
  // number of busy-high samples and done pulses (including the edge after done),
  // and whether product moved before completion.
  task automatic run_op(input logic [N-1:0] ai, input logic [N-1:0] bi,
                        input int inj_at, input bit inj_rst,
                        output int lat, output logic [2*N-1:0] prod,
                        output int busy_n, output int done_n, output bit early_change);
    logic [2*N-1:0] prev;
    bit             finished;
    @(negedge clk);
    prev  = product;
    start = 1'b1;
    a     = ai;
    b     = bi;
    @(posedge clk);
    #1;
    start        = 1'b0;
    lat          = 0;
    prod         = '0;
    busy_n       = busy ? 1 : 0;
    done_n       = 0;
    early_change = (product !== prev);
    finished     = 1'b0;
    while (!finished && lat < N + 8) begin
      if (lat == inj_at) begin
        if (inj_rst) rst = 1'b1;
        else begin
          start = 1'b1;
          a     = 2;
          b     = 2;
        end
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      rst   = 1'b0;
      lat++;
      if (inj_rst && lat == inj_at + 1) begin
        lat      = -1;
        finished = 1'b1;
      end else begin
        if (busy) busy_n++;
        if (done) begin
          done_n++;
          prod     = product;
          finished = 1'b1;
        end else if (product !== prev) early_change = 1'b1;
      end
    end
    if (lat >= 0) begin
      @(posedge clk);
      #1;
      if (busy) busy_n++;
      if (done) done_n++;
    end
  endtask

  // Runs one operation and checks its result, latency, busy window, done pulse and product hold.
  task automatic check_op(input string name, input logic [N-1:0] ai, input logic [N-1:0] bi,
                          input int inj_at, input logic [2*N-1:0] exp_prod, input int exp_lat);
    int             lat;
    int             busy_n;
    int             done_n;
    bit             early;
    logic [2*N-1:0] prod;
    run_op(ai, bi, inj_at, 1'b0, lat, prod, busy_n, done_n, early);
    tests++;
    if (prod !== exp_prod) begin
      fails++;
      $display("FAIL %s product: got %h expected %h", name, prod, exp_prod);
    end
    tests++;
    if (lat !== exp_lat) begin
      fails++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    end
    tests++;
    if (busy_n !== exp_lat + 1) begin
      fails++;
      $display("FAIL %s busy cycles: got %0d expected %0d", name, busy_n, exp_lat + 1);
    end
    tests++;
    if (done_n !== 1) begin
      fails++;
      $display("FAIL %s done pulses: got %0d expected 1", name, done_n);
    end
    tests++;
    if (early !== 1'b0) begin
      fails++;
      $display("FAIL %s product hold: changed before done, expected stable", name);
    end
  endtask

  task automatic test_reset();
    int waited;
    rst   = 1'b1;
    start = 1'b1;
    a     = 3;
    b     = 4;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      tests++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
        fails++;
        $display("FAIL reset_state: busy=%b done=%b product=%h expected 0/0/0", busy, done, product);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL reset_first_start: busy=%b expected 1", busy);
    end
    waited = 0;
    while (done !== 1'b1 && waited < N + 8) begin
      @(posedge clk);
      #1;
      waited++;
    end
    tests++;
    if (done !== 1'b1 || product !== 64'd12) begin
      fails++;
      $display("FAIL reset_first_op: done=%b product=%h expected 1/%h", done, product, 64'd12);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    check_op("3x5", 32'd3, 32'd5, -1, 64'h0000_0000_0000_000F, ref_latency(32'd5));
    check_op("max_x_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 64'hFFFF_FFFE_0000_0001,
             ref_latency(32'hFFFF_FFFF));
    check_op("7x1", 32'd7, 32'd1, -1, 64'd7, ref_latency(32'd1));
    check_op("7x0", 32'd7, 32'd0, -1, 64'd0, ref_latency(32'd0));
    check_op("5x2^31", 32'd5, 32'h8000_0000, -1, 64'h2_8000_0000, ref_latency(32'h8000_0000));
  endtask

  task automatic test_start_ignored();
    check_op("start_while_busy", 32'd9, 32'd7, 4, 64'h3F, ref_latency(32'd7));
  endtask

  task automatic test_reset_in_run();
    int             lat;
    int             busy_n;
    int             done_n;
    bit             early;
    int             stray;
    logic [2*N-1:0] prod;
    run_op(32'hDEAD_BEEF, 32'hFFFF_FFFF, 10, 1'b1, lat, prod, busy_n, done_n, early);
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
      fails++;
      $display("FAIL reset_in_run: busy=%b done=%b product=%h expected 0/0/0", busy, done, product);
    end
    stray = 0;
    for (int i = 0; i < N + 4; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) stray++;
    end
    tests++;
    if (stray !== 0) begin
      fails++;
      $display("FAIL reset_in_run_quiet: %0d busy/done cycles expected 0", stray);
    end
    check_op("after_reset_6x7", 32'd6, 32'd7, -1, 64'd42, ref_latency(32'd7));
  endtask

  task automatic test_random();
    logic [N-1:0] ra;
    logic [N-1:0] rb;
    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if (i == 3) ra = '1;
      if (i == 5) rb = '1;
      check_op($sformatf("random_%0d", i), ra, rb, -1, ref_product(ra, rb), ref_latency(rb));
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] ra;
    logic [N-1:0] rb;
    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom;
      check_op($sformatf("b2b_%0d", i), ra, rb, -1, ref_product(ra, rb), ref_latency(rb));
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    test_reset();
    test_directed();
    test_start_ignored();
    test_reset_in_run();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
